// File: rtl/text_overlay.sv
// text_overlay: game state machine, BCD countdown timer and font-ROM text overlay.
// A pixel presented at cycle N is looked up in the ROM at N+1 and coloured at N+2.
module text_overlay #(
   parameter logic [11:0] FG_COLOR       = 12'hFFF,
   parameter int          TIMER_MIN      = 3,
   parameter int          TIMER_SEC      = 0,
   parameter int          FRAMES_PER_SEC = 60
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic        frame_tick,
   input  logic        start,
   input  logic        player_dead,
   output logic [10:0] rom_addr,
   input  logic [7:0]  font_word,
   output logic [3:0]  text_on,
   output logic [3:0]  text_red,
   output logic [3:0]  text_green,
   output logic [3:0]  text_blue,
   output logic [1:0]  game_state,
   output logic        time_up
);

   typedef enum logic [1:0] {
      ST_TITLE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OVER  = 2'd2,
      ST_BAD   = 2'd3
   } state_t;

   localparam logic [3:0] LOAD_M     = 4'(TIMER_MIN);
   localparam logic [3:0] LOAD_S10   = 4'(TIMER_SEC / 10);
   localparam logic [3:0] LOAD_S1    = 4'(TIMER_SEC % 10);
   localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_SEC - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] tmr_m;
   logic [3:0] tmr_s10;
   logic [3:0] tmr_s1;
   logic [7:0] frame_cnt;
   logic       timer_zero;

   logic       in_title;
   logic       in_prompt;
   logic       in_score;
   logic       in_over;
   logic [9:0] title_dx;
   logic [9:0] prompt_dx;
   logic [9:0] over_dx;
   logic [6:0] char_code;
   logic [3:0] glyph_row;
   logic [2:0] bit_sel;
   logic [3:0] region;
   logic [3:0] region_d;
   logic [2:0] bit_d;
   logic       unused_bits;

   function automatic logic [6:0] title_char(input logic [2:0] idx);
      case (idx)
         3'd0:    return 7'h44;
         3'd1:    return 7'h4F;
         3'd2:    return 7'h4F;
         3'd3:    return 7'h4D;
         default: return 7'h21;
      endcase
   endfunction

   function automatic logic [6:0] prompt_char(input logic [3:0] idx);
      case (idx)
         4'd0:    return 7'h50;
         4'd1:    return 7'h52;
         4'd2:    return 7'h45;
         4'd3:    return 7'h53;
         4'd4:    return 7'h53;
         4'd5:    return 7'h20;
         4'd6:    return 7'h53;
         4'd7:    return 7'h54;
         4'd8:    return 7'h41;
         4'd9:    return 7'h52;
         default: return 7'h54;
      endcase
   endfunction

   function automatic logic [6:0] over_char(input logic [3:0] idx);
      case (idx)
         4'd0:    return 7'h47;
         4'd1:    return 7'h41;
         4'd2:    return 7'h4D;
         4'd3:    return 7'h45;
         4'd4:    return 7'h20;
         4'd5:    return 7'h4F;
         4'd6:    return 7'h56;
         4'd7:    return 7'h45;
         default: return 7'h52;
      endcase
   endfunction

   function automatic logic [6:0] digit_char(input logic [3:0] d);
      return 7'h30 + {3'b000, d};
   endfunction

   assign timer_zero = (tmr_m == 4'd0) && (tmr_s10 == 4'd0) && (tmr_s1 == 4'd0);
   assign time_up    = ((state == ST_PLAY) || (state == ST_OVER)) && timer_zero;
   assign game_state = state;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_TITLE;
      else        state <= state_next;
   end

   // Next-state logic; start is ignored while playing, the unused code recovers to TITLE
   always_comb begin
      state_next = state;
      case (state)
         ST_TITLE: if (start) state_next = ST_PLAY;
         ST_PLAY:  if (player_dead || time_up) state_next = ST_OVER;
         ST_OVER:  if (start) state_next = ST_TITLE;
         default:  state_next = ST_TITLE;
      endcase
   end

   // Countdown timer: reload on game start, tick down once per second of frames, stop at 0:00
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_m     <= LOAD_M;
         tmr_s10   <= LOAD_S10;
         tmr_s1    <= LOAD_S1;
         frame_cnt <= '0;
      end else if ((state == ST_TITLE) && start) begin
         tmr_m     <= LOAD_M;
         tmr_s10   <= LOAD_S10;
         tmr_s1    <= LOAD_S1;
         frame_cnt <= '0;
      end else if ((state == ST_PLAY) && frame_tick) begin
         if (frame_cnt == FRAME_LAST) begin
            frame_cnt <= '0;
            if (!timer_zero) begin
               if (tmr_s1 != 4'd0) begin
                  tmr_s1 <= tmr_s1 - 4'd1;
               end else begin
                  tmr_s1 <= 4'd9;
                  if (tmr_s10 != 4'd0) begin
                     tmr_s10 <= tmr_s10 - 4'd1;
                  end else begin
                     tmr_s10 <= 4'd5;
                     tmr_m   <= tmr_m - 4'd1;
                  end
               end
            end
         end else begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // Region membership; prompt and over boxes are not glyph-aligned so they use offsets
   assign title_dx  = pix_x - 10'd192;
   assign prompt_dx = pix_x - 10'd232;
   assign over_dx   = pix_x - 10'd176;

   assign in_title  = (state == ST_TITLE) && (pix_x >= 10'd192) && (pix_x <= 10'd511)
                      && (pix_y >= 10'd256) && (pix_y <= 10'd383);
   assign in_prompt = (state == ST_TITLE) && (pix_x >= 10'd232) && (pix_x <= 10'd407)
                      && (pix_y >= 10'd416) && (pix_y <= 10'd447);
   assign in_score  = ((state == ST_PLAY) || (state == ST_OVER))
                      && (pix_x <= 10'd63) && (pix_y <= 10'd31);
   assign in_over   = (state == ST_OVER) && (pix_x >= 10'd176) && (pix_x <= 10'd463)
                      && (pix_y >= 10'd192) && (pix_y <= 10'd255);

   assign unused_bits = ^{title_dx[9], title_dx[2:0], prompt_dx[9:8], prompt_dx[0],
                          over_dx[9], over_dx[1:0]};

   // Priority region select: character code, glyph row and bit index for the ROM fetch
   always_comb begin
      region    = 4'b0000;
      char_code = 7'h00;
      glyph_row = 4'h0;
      bit_sel   = 3'd0;
      if (in_title) begin
         region    = 4'b0100;
         char_code = title_char(title_dx[8:6]);
         glyph_row = pix_y[6:3];
         bit_sel   = title_dx[5:3];
      end else if (in_prompt) begin
         region    = 4'b0010;
         char_code = prompt_char(prompt_dx[7:4]);
         glyph_row = pix_y[4:1];
         bit_sel   = prompt_dx[3:1];
      end else if (in_score) begin
         region    = 4'b1000;
         case (pix_x[5:4])
            2'd0:    char_code = digit_char(tmr_m);
            2'd1:    char_code = 7'h3A;
            2'd2:    char_code = digit_char(tmr_s10);
            default: char_code = digit_char(tmr_s1);
         endcase
         glyph_row = pix_y[4:1];
         bit_sel   = pix_x[3:1];
      end else if (in_over) begin
         region    = 4'b0001;
         char_code = over_char(over_dx[8:5]);
         glyph_row = pix_y[5:2];
         bit_sel   = over_dx[4:2];
      end
   end

   assign rom_addr = {char_code, glyph_row};

   // Delay region flags and bit index one cycle so they line up with font_word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         region_d <= '0;
         bit_d    <= '0;
      end else begin
         region_d <= region;
         bit_d    <= bit_sel;
      end
   end

   // Registered pixel output: foreground colour where the glyph bit is set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         text_on    <= '0;
         text_red   <= '0;
         text_green <= '0;
         text_blue  <= '0;
      end else begin
         text_on <= region_d;
         if ((region_d != 4'b0000) && font_word[3'd7 - bit_d]) begin
            {text_red, text_green, text_blue} <= FG_COLOR;
         end else begin
            {text_red, text_green, text_blue} <= 12'h000;
         end
      end
   end

endmodule

// File: tb/tb_text_overlay.sv
// tb_text_overlay: scoreboard bench for text_overlay with a default-timer and a 0:01-timer instance.
module tb_text_overlay;

   localparam logic [11:0] FG = 12'hA5C;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  pix_x, pix_y;
   logic        frame_tick, start, start2, player_dead, player_dead2;

   logic [10:0] rom_addr1, rom_addr2;
   logic [7:0]  font1, font2;
   logic [3:0]  on1, on2;
   logic [3:0]  r1, g1, b1, r2, g2, b2;
   logic [1:0]  gs1, gs2;
   logic        tu1, tu2;

   int     vectors = 0;
   int     miscompares = 0;
   longint edges = 0;

   int exp_state [1:2];
   int exp_m     [1:2];
   int exp_s10   [1:2];
   int exp_s1    [1:2];

   typedef struct packed {
      logic [10:0] addr;
      logic [3:0]  on;
      logic [2:0]  bitn;
   } pix_t;

   typedef struct {
      int          sel;
      logic [3:0]  on;
      logic [11:0] rgb;
      longint      due;
   } sb_t;

   sb_t sbq[$];

   text_overlay #(.FG_COLOR(FG), .TIMER_MIN(3), .TIMER_SEC(0), .FRAMES_PER_SEC(60)) dut1 (
      .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .frame_tick(frame_tick),
      .start(start), .player_dead(player_dead), .rom_addr(rom_addr1), .font_word(font1),
      .text_on(on1), .text_red(r1), .text_green(g1), .text_blue(b1),
      .game_state(gs1), .time_up(tu1));

   text_overlay #(.FG_COLOR(FG), .TIMER_MIN(0), .TIMER_SEC(1), .FRAMES_PER_SEC(60)) dut2 (
      .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .frame_tick(frame_tick),
      .start(start2), .player_dead(player_dead2), .rom_addr(rom_addr2), .font_word(font2),
      .text_on(on2), .text_red(r2), .text_green(g2), .text_blue(b2),
      .game_state(gs2), .time_up(tu2));

   always #5 clk = ~clk;

   function automatic logic [7:0] romFont(input logic [10:0] a);
      return a[7:0] ^ {a[2:0], a[10:6]} ^ 8'h69;
   endfunction

   // Synchronous font ROM models, one per instance
   always @(posedge clk) begin
      font1 <= romFont(rom_addr1);
      font2 <= romFont(rom_addr2);
   end

   always @(posedge clk) edges <= edges + 1;

   function automatic pix_t modelPixel(input int x, input int y, input int st,
                                       input int m, input int s10, input int s1);
      pix_t       r;
      string      title_txt  = "DOOM!";
      string      prompt_txt = "PRESS START";
      string      over_txt   = "GAME OVER";
      logic [7:0] ch;
      r  = '0;
      ch = 8'h00;
      if (st == 0 && x >= 192 && x <= 511 && y >= 256 && y <= 383) begin
         ch = title_txt[(x - 192) / 64];
         r.on = 4'b0100; r.addr = {ch[6:0], 4'((y - 256) / 8)}; r.bitn = 3'(((x - 192) % 64) / 8);
      end else if (st == 0 && x >= 232 && x <= 407 && y >= 416 && y <= 447) begin
         ch = prompt_txt[(x - 232) / 16];
         r.on = 4'b0010; r.addr = {ch[6:0], 4'((y - 416) / 2)}; r.bitn = 3'(((x - 232) % 16) / 2);
      end else if ((st == 1 || st == 2) && x < 64 && y < 32) begin
         case (x / 16)
            0:       ch = 8'(48 + m);
            1:       ch = 8'h3A;
            2:       ch = 8'(48 + s10);
            default: ch = 8'(48 + s1);
         endcase
         r.on = 4'b1000; r.addr = {ch[6:0], 4'(y / 2)}; r.bitn = 3'((x % 16) / 2);
      end else if (st == 2 && x >= 176 && x <= 463 && y >= 192 && y <= 255) begin
         ch = over_txt[(x - 176) / 32];
         r.on = 4'b0001; r.addr = {ch[6:0], 4'((y - 192) / 4)}; r.bitn = 3'(((x - 176) % 32) / 4);
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h, expected %0h at t=%0t", tag, observed, expected, $time);
      end
   endtask

   // Drive one pixel, check the combinational ROM address, queue the pixel result
   task automatic applyStimulus(input int sel, input int x, input int y);
      pix_t       r;
      sb_t        e;
      logic [7:0] fw;
      @(negedge clk);
      pix_x = 10'(x);
      pix_y = 10'(y);
      #1;
      r = modelPixel(x, y, exp_state[sel], exp_m[sel], exp_s10[sel], exp_s1[sel]);
      checkOutput("rom_addr", (sel == 1) ? {21'd0, rom_addr1} : {21'd0, rom_addr2}, {21'd0, r.addr});
      fw    = romFont(r.addr);
      e.sel = sel;
      e.on  = r.on;
      e.rgb = (r.on != 4'b0000 && fw[7 - r.bitn]) ? FG : 12'h000;
      e.due = edges + 2;
      sbq.push_back(e);
   endtask

   // Pop every result whose pipeline latency has elapsed and compare it
   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].due <= edges) begin
         sb_t e;
         e = sbq.pop_front();
         if (e.sel == 1) begin
            checkOutput("text_on1", {28'd0, on1}, {28'd0, e.on});
            checkOutput("rgb1", {20'd0, r1, g1, b1}, {20'd0, e.rgb});
         end else begin
            checkOutput("text_on2", {28'd0, on2}, {28'd0, e.on});
            checkOutput("rgb2", {20'd0, r2, g2, b2}, {20'd0, e.rgb});
         end
      end
   end

   task automatic drain();
      repeat (3) @(negedge clk);
      #1;
      checkOutput("sb_drain", sbq.size(), 0);
   endtask

   task automatic scoreCheck(input int sel);
      applyStimulus(sel, 2, 6);
      applyStimulus(sel, 18, 6);
      applyStimulus(sel, 34, 6);
      applyStimulus(sel, 50, 6);
      checkOutput("s1_char", (sel == 1) ? rom_addr1[10:4] : rom_addr2[10:4], 7'(48 + exp_s1[sel]));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) frame_tick = 1'b1;
         @(negedge clk) frame_tick = 1'b0;
      end
   endtask

   task automatic pulseInputs(input logic s1, input logic s2, input logic pd);
      @(negedge clk);
      start = s1; start2 = s2; player_dead = pd;
      @(negedge clk);
      start = 1'b0; start2 = 1'b0; player_dead = 1'b0;
   endtask

   task automatic setTimer(input int sel, input int m, input int s10, input int s1);
      exp_m[sel] = m; exp_s10[sel] = s10; exp_s1[sel] = s1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0; pix_x = '0; pix_y = '0;
      frame_tick = 0; start = 0; start2 = 0; player_dead = 0; player_dead2 = 0;
      exp_state[1] = 0; exp_state[2] = 0;
      setTimer(1, 3, 0, 0);
      setTimer(2, 0, 0, 1);

      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_gs1", gs1, 0);
      checkOutput("reset_tu1", tu1, 0);
      checkOutput("reset_on1", on1, 0);
      checkOutput("reset_rgb1", {r1, g1, b1}, 0);
      checkOutput("reset_gs2", gs2, 0);
      @(negedge clk) rst_n = 1'b1;

      // Title screen contents
      applyStimulus(1, 200, 260);
      checkOutput("title_D_char", rom_addr1[10:4], 7'h44);
      for (int x = 192; x < 512; x += 24) applyStimulus(1, x, 300);
      applyStimulus(1, 511, 383);
      applyStimulus(1, 232, 420);
      checkOutput("prompt_P_char", rom_addr1[10:4], 7'h50);
      for (int x = 236; x < 408; x += 34) applyStimulus(1, x, 431);
      applyStimulus(1, 700, 500);
      applyStimulus(1, 10, 10);
      applyStimulus(1, 200, 200);
      drain();

      // Start both games; a 59-tick run must not decrement yet
      pulseInputs(1, 1, 0);
      exp_state[1] = 1; exp_state[2] = 1;
      checkOutput("gs1_play", gs1, 1);
      checkOutput("gs2_play", gs2, 1);
      ticks(59);
      checkOutput("tu2_before", tu2, 0);
      scoreCheck(1);
      scoreCheck(2);
      drain();

      // Sixtieth tick: 2:59 on the default timer, 0:00 and game over on the short one
      ticks(1);
      setTimer(1, 2, 5, 9);
      setTimer(2, 0, 0, 0);
      checkOutput("tu2_zero", tu2, 1);
      checkOutput("gs2_still_play", gs2, 1);
      checkOutput("tu1_running", tu1, 0);
      @(negedge clk);
      checkOutput("gs2_over", gs2, 2);
      exp_state[2] = 2;
      scoreCheck(1);
      scoreCheck(2);
      applyStimulus(2, 180, 196);
      applyStimulus(2, 460, 250);
      applyStimulus(2, 300, 220);
      applyStimulus(1, 180, 196);
      drain();

      // Another second: default timer moves, expired timer holds
      ticks(60);
      setTimer(1, 2, 5, 8);
      checkOutput("tu2_hold", tu2, 1);
      scoreCheck(1);
      scoreCheck(2);
      drain();

      // start together with player_dead in PLAY -> OVER
      pulseInputs(1, 0, 1);
      exp_state[1] = 2;
      checkOutput("gs1_dead_over", gs1, 2);
      checkOutput("tu1_over", tu1, 0);
      scoreCheck(1);
      applyStimulus(1, 300, 220);
      drain();

      // OVER -> TITLE -> PLAY with reload; start alone in PLAY is ignored
      pulseInputs(1, 0, 0);
      exp_state[1] = 0;
      checkOutput("gs1_title", gs1, 0);
      applyStimulus(1, 300, 300);
      pulseInputs(1, 0, 0);
      exp_state[1] = 1;
      setTimer(1, 3, 0, 0);
      checkOutput("gs1_replay", gs1, 1);
      scoreCheck(1);
      drain();
      pulseInputs(1, 0, 0);
      checkOutput("gs1_start_ignored", gs1, 1);

      // Run down to 1:23 (97 seconds)
      ticks(97 * 60);
      setTimer(1, 1, 2, 3);
      checkOutput("gs1_mid", gs1, 1);
      scoreCheck(1);
      applyStimulus(1, 3, 2);
      drain();
      checkOutput("pre_reset_on", on1, 4'b1000);

      // Asynchronous reset in the middle of a clock period
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("areset_gs1", gs1, 0);
      checkOutput("areset_tu1", tu1, 0);
      checkOutput("areset_on1", on1, 0);
      checkOutput("areset_rgb1", {r1, g1, b1}, 0);
      checkOutput("areset_gs2", gs2, 0);
      checkOutput("areset_tu2", tu2, 0);
      checkOutput("areset_on2", on2, 0);
      exp_state[1] = 0; exp_state[2] = 0;
      setTimer(1, 3, 0, 0);
      setTimer(2, 0, 0, 1);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      applyStimulus(1, 3, 2);
      applyStimulus(1, 250, 270);
      drain();

      pulseInputs(1, 1, 0);
      exp_state[1] = 1; exp_state[2] = 1;
      scoreCheck(1);
      scoreCheck(2);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/text_overlay.md
TEXT_OVERLAY -- requirements
Module: text_overlay

Interface
REQ-001 The block SHALL have parameter FG_COLOR, default 12'hFFF, meaning the {red,green,blue} text colour.
REQ-002 The block SHALL have parameter TIMER_MIN, default 3, meaning the BCD minutes loaded at game start (0-9).
REQ-003 The block SHALL have parameter TIMER_SEC, default 0, meaning the binary seconds loaded at game start (0-59).
REQ-004 The block SHALL have parameter FRAMES_PER_SEC, default 60, meaning the frame_tick pulses per timer second (2-255).
REQ-005 The block SHALL have one clock, clk  in  1  pixel clock; all state changes on its rising edge.
REQ-006 The block SHALL have reset  in  1; reset is asynchronous and active-low.
REQ-007 The block SHALL have pix_x  in  10  current pixel column, 0-639.
REQ-008 The block SHALL have pix_y  in  10  current pixel row, 0-479.
REQ-009 The block SHALL have frame_tick  in  1  one-cycle pulse, once per frame.
REQ-010 The block SHALL have start  in  1  level, sampled every cycle.
REQ-011 The block SHALL have player_dead  in  1  level, sampled every cycle.
REQ-012 The block SHALL have rom_addr  out  11  {char[6:0], row[3:0]} to the synchronous font ROM.
REQ-013 The block SHALL have font_word  in  8  ROM data, valid 1 cycle after rom_addr.
REQ-014 The block SHALL have text_on  out  4  {score, title, prompt, over}, pixel-aligned with RGB.
REQ-015 The block SHALL have text_red, text_green, text_blue  out  4 each, registered pixel colour.
REQ-016 The block SHALL have game_state  out  2  TITLE=0, PLAY=1, OVER=2.
REQ-017 The block SHALL have time_up  out  1  high while the timer reads 0:00 in PLAY or OVER.

Function
REQ-018 The FSM SHALL transition TITLE->PLAY on start, PLAY->OVER on player_dead or time_up, OVER->TITLE on start; start SHALL be ignored in PLAY; encoding 3 SHALL go to TITLE.
REQ-019 On entering PLAY the timer SHALL load TIMER_MIN:TIMER_SEC as BCD M, S10, S1 and SHALL clear the frame counter.
REQ-020 In PLAY a frame_tick with frame counter = FRAMES_PER_SEC-1 SHALL clear the counter and decrement the timer once; any other frame_tick SHALL increment the counter.
REQ-021 Decrement SHALL borrow S1 0->9 from S10, and S10 0->5 from M; at 0:00 the timer SHALL hold and never wrap to 9:59.
REQ-022 The timer and frame counter SHALL hold in TITLE and OVER.
REQ-023 The score region SHALL be y 0-31, x 0-63, with 16x32 glyphs (row=y[4:1], bit=x[3:1]) showing M, ':', S10, S1 as ASCII 0x30+digit and 0x3A; it SHALL be active in PLAY and OVER.
REQ-024 The title region SHALL be y 256-383, x 192-511, with 64x128 glyphs (row=y[6:3], bit=x[5:3]) showing "DOOM!"; it SHALL be active in TITLE only.
REQ-025 The prompt region SHALL be y 416-447, x 232-407, with 16x32 glyphs showing "PRESS START" (11 chars); it SHALL be active in TITLE only.
REQ-026 The over region SHALL be y 192-255, x 176-463, with 32x64 glyphs (row=y[5:2], bit=x[4:2]) showing "GAME OVER"; it SHALL be active in OVER only.
REQ-027 Region priority for rom_addr SHALL be title > prompt > score > over; outside all regions rom_addr SHALL be 0.
REQ-028 rom_addr SHALL be combinational from pix_x, pix_y and registered timer/state; region flags and bit index SHALL be delayed 1 cycle to meet font_word.
REQ-029 Outputs SHALL be registered: pixel (x,y) presented at cycle N SHALL appear on text_on and RGB at cycle N+2.
REQ-030 RGB SHALL be FG_COLOR when the delayed region flag is set and font_word[7-bit] = 1, else 0; there SHALL be no latched state.
REQ-031 A timer digit change SHALL take effect at the next pixel fetched; mid-frame tearing of the score is accepted.

Reset
REQ-032 Reset low SHALL immediately force game_state=TITLE, timer=TIMER_MIN:TIMER_SEC, frame counter=0, time_up=0, text_on=0, and RGB=0, including mid-frame or mid-game.
REQ-033 The first rising clk after reset deasserts SHALL resume normal pipeline operation, with its outputs valid from the second edge.

Verification
REQ-034 Reset, then pixel (200,260) in TITLE with a ROM model -> text_on=4'b0100 two cycles later, rom_addr char=0x44 ('D'), RGB per glyph bit.
REQ-035 start pulse, then 60 frame_ticks -> timer 3:00->2:59, score char at x 48-63 = 0x39.
REQ-036 TIMER_MIN=0, TIMER_SEC=1, start, 60 ticks -> 0:00, time_up=1, game_state=OVER next cycle, over region lit, and further ticks leave the timer unchanged.
REQ-037 start and player_dead high together in PLAY -> OVER; start in OVER -> TITLE; start in TITLE -> PLAY with the timer reloaded.
REQ-038 Assert reset mid-PLAY at 1:23 -> TITLE, timer 3:00, and all outputs 0 asynchronously before the next clk edge.
REQ-039 Pixel (700,500) or a glyph-zero bit -> RGB=0; text_on=0 outside all regions.
